// File: rtl/digit_serial_adder_if.sv
// Operand and result handshake bundle for digit_serial_adder.
// The master drives operands and out_ready; the slave (the adder) drives the result side.
interface digit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] InA;
    logic [WIDTH-1:0] InB;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] OutSum;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, InA, InB, op, out_ready,
        input  in_ready, out_valid, OutSum, carry, overflow
    );

    modport slave (
        input  in_valid, InA, InB, op, out_ready,
        output in_ready, out_valid, OutSum, carry, overflow
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement add/sub/accumulate, DIGIT bits per clock, WIDTH/DIGIT cycles per op.
// Optional macro ADDER_SATURATE_EN clamps the result on signed overflow instead of wrapping.
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    digit_serial_adder_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             cy_q, cy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT:0]   digit_sum_s;
    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;
    logic [WIDTH-1:0] shift_sum_s;
    logic [WIDTH-1:0] final_sum_s;
    logic             carry_msb_in_s;
    logic             ovf_s;
    logic             last_digit_s;

    // Single DIGIT-wide adder slice fed by the low digit of each captured operand.
    assign digit_sum_s    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                          + {{DIGIT{1'b0}}, cy_q};
    assign carry_msb_in_s = digit_sum_s[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    assign ovf_s          = carry_msb_in_s ^ digit_sum_s[DIGIT];
    assign last_digit_s   = (cnt_q == CNT_W'(N - 1));

    // The OutSum register doubles as the result shift register while out_valid is low.
    if (DIGIT == WIDTH) begin : g_single
        assign a_next_s    = a_q;
        assign b_next_s    = b_q;
        assign shift_sum_s = digit_sum_s[DIGIT-1:0];
    end else begin : g_multi
        assign a_next_s    = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
        assign b_next_s    = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
        assign shift_sum_s = {digit_sum_s[DIGIT-1:0], sum_q[WIDTH-1:DIGIT]};
    end

`ifdef ADDER_SATURATE_EN
    // On overflow both operands share A's sign, which is also the true result sign.
    assign final_sum_s = !ovf_s ? shift_sum_s :
                         (a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign final_sum_s = shift_sum_s;
`endif

    // Next-state and datapath control for IDLE / CALC / DONE.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cy_d        = cy_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d  = bus.InA;
                    op_d = bus.op;
                    cy_d = (bus.op == OP_SUB);
                    case (bus.op)
                        OP_ADD:  b_d = bus.InB;
                        OP_SUB:  b_d = ~bus.InB;
                        OP_ACC:  b_d = acc_q;
                        OP_LOAD: b_d = {WIDTH{1'b0}};
                        default: b_d = {WIDTH{1'b0}};
                    endcase
                    cnt_d      = {CNT_W{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = S_CALC;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_CALC: begin
                a_d   = a_next_s;
                b_d   = b_next_s;
                cy_d  = digit_sum_s[DIGIT];
                sum_d = shift_sum_s;
                if (last_digit_s) begin
                    sum_d       = final_sum_s;
                    carry_d     = (op_q == OP_LOAD) ? 1'b0 : digit_sum_s[DIGIT];
                    ovf_d       = (op_q == OP_LOAD) ? 1'b0 : ovf_s;
                    cnt_d       = {CNT_W{1'b0}};
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                    if (op_q[1]) begin
                        acc_d = final_sum_s;
                    end else begin
                        acc_d = acc_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            op_q        <= 2'b00;
            cy_q        <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cy_q        <= cy_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.OutSum    = sum_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised, multi-cycle successor to the team's 4-bit combinational adder. It adds, subtracts or accumulates two's-complement operands of configurable width, DIGIT bits per clock, through a single DIGIT-wide adder slice with a carry register. Operands enter and results leave through independent valid/ready handshakes, so the block can sit between a stimulus or register-file front end and any back-pressuring consumer. It reports both unsigned carry-out and signed overflow.

## Interface
- WIDTH, 8, operand/result width in bits; WIDTH >= 2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly; N = WIDTH/DIGIT cycles per operation.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle (InA, InB, op) valid.
- in_ready  output  1  block can accept an operand bundle.
- InA  input  WIDTH  operand A, two's complement.
- InB  input  WIDTH  operand B, two's complement (ignored for op 10/11).
- op  input  2  00 A+B, 01 A-B, 10 ACC+A, 11 load ACC with A.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts result.
- OutSum  output  WIDTH  result.
- carry  output  1  unsigned carry out of MSB (op 01: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid & in_ready, capture InA, second operand (InB, ~InB, or ACC per op), op; set carry-in (1 for op 01, else 0); clear digit counter; go to CALC.
- CALC: each cycle add digit i of both captured operands plus carry register; write DIGIT result bits into result shift register; update carry; increment counter. After digit N-1, go to DONE.
- Overflow = carry into MSB XOR carry out of MSB, computed on the final digit.
- op 11: result = A, carry=0, overflow=0; still takes N cycles, for uniform latency.
- Entering DONE: OutSum/carry/overflow registered; for op 10 and 11 ACC <= OutSum (final value, post-saturation if enabled). ops 00/01 leave ACC unchanged.
- DONE: out_valid=1; outputs held stable until out_valid & out_ready, then IDLE.
- Inputs are sampled only at the acceptance edge; changes during CALC/DONE are ignored. in_valid outside IDLE is ignored, not queued.
- Arithmetic is modulo 2^WIDTH (wrap) unless saturation is compiled in.

## Timing
- Reset (any state, including mid-CALC or DONE): state IDLE, in_ready=1 from the first cycle after reset, out_valid=0, OutSum=0, carry=0, overflow=0, ACC=0, counter=0; an in-flight operation is discarded.
- Latency: accept on edge k -> out_valid high after edge k+N (N=2 for defaults).
- Throughput: one operation per N+2 cycles with out_ready held high (accept, N CALC, DONE handshake, IDLE).
- in_ready is 0 in CALC and DONE; returns to 1 the cycle after the output handshake.
- out_valid never deasserts without out_ready.
- DIGIT == WIDTH: N=1, single CALC cycle; behaviour otherwise identical.

## Configuration
- ADDER_SATURATE_EN defined: when overflow=1, OutSum clamps to 0 followed by ones (max positive) if the true result is positive, or 1 followed by zeros (min negative) if negative. overflow still reads 1; carry unchanged; ACC stores the clamped value.
- Undefined: OutSum wraps (modulo 2^WIDTH); no clamp logic is synthesised.

## Test plan
- Reset: hold rst 2 cycles mid-CALC -> out_valid=0, OutSum=0x00, carry=0, overflow=0; in_ready=1 on the next cycle.
- Add: op 00, 0x45+0x27 -> OutSum=0x6C, carry=0, overflow=0, out_valid exactly 2 cycles after acceptance; 0xFF+0x01 -> 0x00, carry=1, overflow=0.
- Signed overflow: op 00, 0x70+0x20 -> overflow=1, OutSum=0x90 (wrap) or 0x7F (ADDER_SATURATE_EN).
- Subtract: op 01, 0x10-0x20 -> 0xF0, carry=0, overflow=0; 0x80-0x01 -> overflow=1, OutSum=0x7F (wrap) or 0x80 (saturate).
- Back-pressure: out_ready low 5 cycles in DONE while in_valid toggles with new operands -> OutSum/flags constant, in_ready=0, no operand captured; result transfers on the out_ready rise.
- Accumulate: op 11 A=0x05, then op 10 A=0x03 three times -> 0x05, 0x08, 0x0B, 0x0E; reset, then op 10 A=0x01 -> 0x01.
